// File: rtl/qtable_updater.sv
// qtable_updater: single-step Q-learning update engine over an external Q table.
// Define QUPD_SAT_EN to saturate the new Q value; the default build wraps it.
module qtable_updater #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ACT_WIDTH   = 2,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [ADDR_WIDTH-ACT_WIDTH-1:0] i_state,
  input  logic [ADDR_WIDTH-ACT_WIDTH-1:0] i_next_state,
  input  logic [ACT_WIDTH-1:0]            i_action,
  input  logic [DATA_WIDTH-1:0]           i_reward,
  input  logic                            i_terminal,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [DATA_WIDTH-1:0]           o_q_new,
  output logic [ACT_WIDTH-1:0]            o_greedy_action,
  output logic [ADDR_WIDTH-1:0]           o_addr_r,
  output logic [ADDR_WIDTH-1:0]           o_addr_w,
  output logic                            o_read_en,
  output logic                            o_write_en,
  output logic [DATA_WIDTH-1:0]           o_wdata,
  input  logic [DATA_WIDTH-1:0]           i_rdata
);
  localparam int SW = ADDR_WIDTH - ACT_WIDTH;
  localparam int EW = DATA_WIDTH + 3;

  // IDLE wait start | RD_CUR read Q(s,a) | RD_NEXT read Q(s',k) | WAIT last word
  // CALC form Q_new | WRITE store Q_new | DONE completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_RD_CUR, S_RD_NEXT, S_WAIT, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t                       r_state;
  logic [SW-1:0]                r_s;
  logic [SW-1:0]                r_ns;
  logic [ACT_WIDTH-1:0]         r_a;
  logic signed [DATA_WIDTH-1:0] r_reward;
  logic                         r_term;
  logic [ACT_WIDTH-1:0]         r_k;
  logic                         r_cap_vld;
  logic                         r_cap_cur;
  logic [ACT_WIDTH-1:0]         r_cap_k;
  logic signed [DATA_WIDTH-1:0] r_qcur;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic [ACT_WIDTH-1:0]         r_arg;

  logic signed [DATA_WIDTH-1:0] w_rdata;
  logic signed [EW-1:0]         w_qcur;
  logic signed [EW-1:0]         w_max;
  logic signed [EW-1:0]         w_rew;
  logic signed [EW-1:0]         w_fut;
  logic signed [EW-1:0]         w_delta;
  logic signed [EW-1:0]         w_qsum;
  logic [DATA_WIDTH-1:0]        w_qnew;

  assign w_rdata = $signed(i_rdata);
  assign w_qcur  = {{3{r_qcur[DATA_WIDTH-1]}}, r_qcur};
  assign w_max   = {{3{r_max[DATA_WIDTH-1]}}, r_max};
  assign w_rew   = {{3{r_reward[DATA_WIDTH-1]}}, r_reward};

  always_comb begin
    w_fut = '0;
    if (!r_term) w_fut = w_max - (w_max >>> GAMMA_SHIFT);
    w_delta = w_rew + w_fut - w_qcur;
    w_qsum  = w_qcur + (w_delta >>> ALPHA_SHIFT);
  end

`ifdef QUPD_SAT_EN
  localparam logic signed [EW-1:0] SAT_HI = {4'b0000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_LO = {4'b1111, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    w_qnew = DATA_WIDTH'(w_qsum);
    if (w_qsum > SAT_HI)      w_qnew = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_qsum < SAT_LO) w_qnew = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end
`else
  assign w_qnew = DATA_WIDTH'(w_qsum);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state         <= S_IDLE;
      r_s             <= '0;
      r_ns            <= '0;
      r_a             <= '0;
      r_reward        <= '0;
      r_term          <= 1'b0;
      r_k             <= '0;
      r_cap_vld       <= 1'b0;
      r_cap_cur       <= 1'b0;
      r_cap_k         <= '0;
      r_qcur          <= '0;
      r_max           <= '0;
      r_arg           <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_q_new         <= '0;
      o_greedy_action <= '0;
      o_addr_r        <= '0;
      o_addr_w        <= '0;
      o_read_en       <= 1'b0;
      o_write_en      <= 1'b0;
      o_wdata         <= '0;
    end else begin
      // Read data lands one cycle after the strobe; first word is Q(s,a).
      r_cap_vld <= o_read_en;
      r_cap_cur <= (r_state == S_RD_CUR);
      r_cap_k   <= r_k;
      if (r_cap_vld) begin
        if (r_cap_cur) begin
          r_qcur <= w_rdata;
        end else if (r_cap_k == '0 || w_rdata > r_max) begin
          r_max <= w_rdata;
          r_arg <= r_cap_k;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_s       <= i_state;
            r_ns      <= i_next_state;
            r_a       <= i_action;
            r_reward  <= $signed(i_reward);
            r_term    <= i_terminal;
            o_busy    <= 1'b1;
            o_read_en <= 1'b1;
            o_addr_r  <= {i_state, i_action};
            r_state   <= S_RD_CUR;
          end
        end
        S_RD_CUR: begin
          r_k <= '0;
          if (r_term) begin
            o_read_en <= 1'b0;
            r_state   <= S_WAIT;
          end else begin
            o_addr_r <= {r_ns, {ACT_WIDTH{1'b0}}};
            r_state  <= S_RD_NEXT;
          end
        end
        S_RD_NEXT: begin
          if (r_k == '1) begin
            o_read_en <= 1'b0;
            r_state   <= S_WAIT;
          end else begin
            r_k      <= r_k + 1'b1;
            o_addr_r <= {r_ns, r_k + 1'b1};
          end
        end
        S_WAIT: r_state <= S_CALC;
        S_CALC: begin
          o_q_new    <= w_qnew;
          o_wdata    <= w_qnew;
          o_addr_w   <= {r_s, r_a};
          o_write_en <= 1'b1;
          if (!r_term) o_greedy_action <= r_arg;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          o_write_en <= 1'b0;
          o_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qtable_updater.sv
// Bench for qtable_updater: transaction-level reference model checked every cycle,
// directed literal cases, then randomized updates with start/reset noise.
module tb_qtable_updater;
  localparam int GSH = 1;
  localparam int ASH = 2;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [5:0]  i_state;
  logic [5:0]  i_next_state;
  logic [1:0]  i_action;
  logic [31:0] i_reward;
  logic        i_terminal;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_q_new;
  logic [1:0]  o_greedy_action;
  logic [7:0]  o_addr_r;
  logic [7:0]  o_addr_w;
  logic        o_read_en;
  logic        o_write_en;
  logic [31:0] o_wdata;
  logic [31:0] i_rdata;

  qtable_updater dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_state(i_state),
    .i_next_state(i_next_state), .i_action(i_action), .i_reward(i_reward),
    .i_terminal(i_terminal), .o_busy(o_busy), .o_done(o_done), .o_q_new(o_q_new),
    .o_greedy_action(o_greedy_action), .o_addr_r(o_addr_r), .o_addr_w(o_addr_w),
    .o_read_en(o_read_en), .o_write_en(o_write_en), .o_wdata(o_wdata), .i_rdata(i_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Table RAM behind the DUT (the environment, not the model).
  logic [31:0] mem [256];
  logic        poke_en;
  logic [7:0]  poke_addr;
  logic [31:0] poke_val;

  always @(posedge i_clk) begin
    if (poke_en) mem[poke_addr] <= poke_val;
    else if (o_write_en) mem[o_addr_w] <= o_wdata;
    if (o_read_en) i_rdata <= mem[o_addr_r];
  end

  function automatic logic [31:0] model_q(input longint q, input longint m,
                                          input longint r, input bit t);
    longint f, d, n;
    f = 0;
    if (!t) f = m - (m >>> GSH);
    d = r + f - q;
    n = q + (d >>> ASH);
`ifdef QUPD_SAT_EN
    if (n > 64'sd2147483647) n = 64'sd2147483647;
    else if (n < -64'sd2147483648) n = -64'sd2147483648;
`endif
    return n[31:0];
  endfunction

  // Reference model: table contents plus the timeline of the update in flight.
  logic [31:0] ref_q [256];
  bit          m_known = 0, m_act = 0, m_rst_cyc = 0, m_t = 0;
  int          m_rel = 0, m_len = 0;
  logic [5:0]  m_s, m_ns;
  logic [1:0]  m_a, m_g, h_g, kk, g;
  logic [31:0] m_qn, h_qn;
  logic [7:0]  ea;
  longint      qc, mx, v;
  bit          exp_rd, exp_wr, exp_dn;

  always @(negedge i_clk) begin
    if (m_known) begin
      exp_rd = m_act && (m_rel == 1 || (!m_t && m_rel >= 2 && m_rel <= 5));
      exp_wr = m_act && (m_rel == m_len - 1);
      exp_dn = m_act && (m_rel == m_len);
      chk("busy", o_busy, m_act);
      chk("done", o_done, exp_dn);
      chk("read_en", o_read_en, exp_rd);
      chk("write_en", o_write_en, exp_wr);
      if (exp_rd) begin
        if (m_rel == 1) ea = {m_s, m_a};
        else begin
          kk = 2'(m_rel - 2);
          ea = {m_ns, kk};
        end
        chk("addr_r", o_addr_r, ea);
      end
      if (exp_wr) begin
        chk("addr_w", o_addr_w, {m_s, m_a});
        chk("wdata", o_wdata, m_qn);
      end
      if (!m_act || exp_dn) begin
        chk("q_new", o_q_new, h_qn);
        chk("greedy", o_greedy_action, h_g);
      end
      if (m_rst_cyc) begin
        chk("rst_addr_r", o_addr_r, 0);
        chk("rst_addr_w", o_addr_w, 0);
        chk("rst_wdata", o_wdata, 0);
      end
    end
    // advance the model across the coming rising edge
    if (poke_en) ref_q[poke_addr] = poke_val;
    if (i_rst === 1'b0) begin
      m_known = 1; m_act = 0; m_rst_cyc = 1; h_qn = '0; h_g = '0;
    end else begin
      m_rst_cyc = 0;
      if (m_act) begin
        m_rel++;
        if (m_rel == m_len - 1) begin
          ref_q[{m_s, m_a}] = m_qn;
          h_qn = m_qn;
          if (!m_t) h_g = m_g;
        end
        if (m_rel > m_len) m_act = 0;
      end else if (i_start === 1'b1 && m_known) begin
        m_s = i_state; m_ns = i_next_state; m_a = i_action; m_t = i_terminal;
        qc = $signed(ref_q[{i_state, i_action}]);
        mx = 0; g = '0;
        for (int k = 0; k < 4; k++) begin
          kk = k[1:0];
          v = $signed(ref_q[{i_next_state, kk}]);
          if (k == 0 || v > mx) begin mx = v; g = kk; end
        end
        m_qn = model_q(qc, mx, $signed(i_reward), i_terminal);
        m_g = g;
        m_len = i_terminal ? 5 : 9;
        m_rel = 1;
        m_act = 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] ad, input logic [31:0] val);
    poke_en = 1'b1; poke_addr = ad; poke_val = val;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic set_ops(input int s, input int ns, input int a,
                         input logic [31:0] r, input bit t);
    i_state = 6'(s); i_next_state = 6'(ns); i_action = 2'(a);
    i_reward = r; i_terminal = t;
  endtask

  task automatic run_upd(input int s, input int ns, input int a,
                         input logic [31:0] r, input bit t, output int lat);
    set_ops(s, ns, a, r, t);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    lat = 1;
    while (o_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (o_done !== 1'b1) chk("timeout_done", o_done, 1);
    tick();
  endtask

  int lat;

  initial begin
    i_rst = 1'b0; i_start = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    set_ops(0, 0, 0, 0, 0);
    repeat (3) tick();
    i_rst = 1'b1;
    chk("rst_busy_lit", o_busy, 0);
    chk("rst_qnew_lit", o_q_new, 0);
    chk("rst_greedy_lit", o_greedy_action, 0);

    for (int ad = 0; ad < 256; ad++) begin
      if ($urandom_range(0, 3) == 0) poke(8'(ad), $urandom);
      else poke(8'(ad), 32'($urandom_range(0, 2000)) - 32'd1000);
    end

    // Q=100, next {10,40,-5,40}, r=20 -> 85, greedy 1 (tie on 40 goes to 1)
    poke({6'd10, 2'd3}, 32'd100);
    poke({6'd11, 2'd0}, 32'd10);
    poke({6'd11, 2'd1}, 32'd40);
    poke({6'd11, 2'd2}, 32'hFFFF_FFFB);
    poke({6'd11, 2'd3}, 32'd40);
    run_upd(10, 11, 3, 32'd20, 1'b0, lat);
    chk("lat_nonterm", lat, 9);
    chk("q_85", o_q_new, 85);
    chk("greedy_1", o_greedy_action, 1);
    chk("mem_85", mem[{6'd10, 2'd3}], 85);

    // terminal r=64 from 0 -> 16, then back-to-back -> 28; greedy untouched
    poke({6'd12, 2'd0}, 32'd0);
    run_upd(12, 13, 0, 32'd64, 1'b1, lat);
    chk("lat_term", lat, 5);
    chk("q_16", o_q_new, 16);
    chk("greedy_held", o_greedy_action, 1);
    run_upd(12, 13, 0, 32'd64, 1'b1, lat);
    chk("q_28", o_q_new, 28);
    chk("mem_28", mem[{6'd12, 2'd0}], 28);

    // overflow case
    poke({6'd14, 2'd1}, 32'h7FFF_FFFF);
    for (int k = 0; k < 4; k++) poke({6'd15, 2'(k)}, 32'h7FFF_FFFF);
    run_upd(14, 15, 1, 32'h7FFF_FFFF, 1'b0, lat);
`ifdef QUPD_SAT_EN
    chk("q_sat", o_q_new, 32'h7FFF_FFFF);
`else
    chk("q_wrap", o_q_new, 32'h8FFF_FFFF);
`endif

    // start pulses at cycles 2 and 4 of a running update are ignored
    poke({6'd5, 2'd2}, 32'd0);
    poke({6'd6, 2'd1}, 32'd0);
    set_ops(5, 7, 2, 32'd64, 1'b1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    set_ops(6, 7, 1, 32'd1000, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("done_c5", o_done, 1);
    tick();
    chk("mem_first_ops", mem[{6'd5, 2'd2}], 16);
    chk("mem_second_ops", mem[{6'd6, 2'd1}], 0);

    // reset during RD_NEXT aborts without write, then a fresh update
    poke({6'd16, 2'd0}, 32'd100);
    poke({6'd17, 2'd0}, 32'd10);
    poke({6'd17, 2'd1}, 32'd40);
    poke({6'd17, 2'd2}, 32'hFFFF_FFFB);
    poke({6'd17, 2'd3}, 32'd40);
    set_ops(16, 17, 0, 32'd20, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    chk("abort_busy", o_busy, 0);
    chk("abort_rd", o_read_en, 0);
    repeat (8) tick();
    chk("abort_nowrite", mem[{6'd16, 2'd0}], 100);
    run_upd(16, 17, 0, 32'd20, 1'b0, lat);
    chk("lat_fresh", lat, 9);
    chk("mem_fresh", mem[{6'd16, 2'd0}], 85);

    // randomized traffic over a small state space so updates collide
    for (int c = 0; c < 1500; c++) begin
      i_state      = 6'($urandom_range(0, 3));
      i_next_state = 6'($urandom_range(0, 3));
      i_action     = 2'($urandom_range(0, 3));
      i_terminal   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) i_reward = $urandom;
      else i_reward = 32'($urandom_range(0, 400)) - 32'd200;
      i_start = ($urandom_range(0, 2) == 0);
      i_rst   = !($urandom_range(0, 99) == 0);
      tick();
    end
    i_start = 1'b0;
    i_rst = 1'b1;
    repeat (15) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
